// File: rtl/mips_pkg.sv
// Shared MIPS32 datapath constants: access-size encodings, MEM-stage FSM
// state codes and the hard-wired zero register number.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 also decodes as word

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus with byte lanes.
// master: the MEM pipeline stage; slave: the data memory.
interface mem_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            dm_req;
  logic            dm_we;
  logic [AW-1:0]   dm_addr;
  logic [DW/8-1:0] dm_be;
  logic [DW-1:0]   dm_wdata;
  logic [DW-1:0]   dm_rdata;
  logic            dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ack
  );

endinterface

// File: rtl/mem_lane.sv
// Byte-lane steering for the MEM stage: byte enables, store-data
// replication and load extract with zero/sign extension.
module mem_lane
  import mips_pkg::*;
(
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] loadData
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Select lanes by size; halfwords only look at addrLo[1], words at nothing.
  always_comb begin
    be       = 4'b1111;
    wdata    = storeData;
    loadData = rdata;
    byteVal  = 8'(rdata >> {addrLo, 3'b000});
    halfVal  = 16'(rdata >> {addrLo[1], 4'b0000});
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << addrLo;
        wdata    = {4{storeData[7:0]}};
        loadData = sext ? {{24{byteVal[7]}}, byteVal} : {24'h0, byteVal};
      end
      SZ_HALF: begin
        be       = 4'b0011 << {addrLo[1], 1'b0};
        wdata    = {2{storeData[15:0]}};
        loadData = sext ? {{16{halfVal[15]}}, halfVal} : {16'h0, halfVal};
      end
      SZ_WORD, 2'b11: begin
        be       = 4'b1111;
        wdata    = storeData;
        loadData = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS32 MEM stage: drives the data-memory req/ack bus, stalls the
// pipeline while an access is outstanding and registers MEM/WB.
// Optional: define MEM_STAGE_ADDR_CHECK_EN to trap misaligned half/word
// accesses (o_adel / o_ades) instead of aligning them down.
module mem_stage
  import mips_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_busC,
  input  logic [31:0] i_busB,
  input  logic [4:0]  i_rd,
  input  logic        i_valid,
  input  logic        i_memrd,
  input  logic        i_memwr,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  mem_stage_if.master dm,
  output logic [31:0] o_busW,
  output logic [4:0]  o_rd,
  output logic        o_we,
  output logic        o_valid,
  output logic        o_stall
`ifdef MEM_STAGE_ADDR_CHECK_EN
  ,
  output logic        o_adel,
  output logic        o_ades
`endif
);

  logic [0:0]      state, stateNext;
  logic            inWait;
  logic            isMem, isStore, memGo;
  logic            reqInt, captureEn;

  // Copies of the request taken when an access has to wait for memory.
  logic [31:0]     addrQ, dataQ;
  logic [1:0]      sizeQ;
  logic            sextQ, storeQ;
  logic [4:0]      rdQ;

  // Lane-logic operands: live inputs in IDLE, captured copies in WAIT.
  logic [31:0]     selAddr, selData;
  logic [1:0]      selSize;
  logic            selSext, selStore;
  logic [4:0]      selRd;

  logic [DW/8-1:0] laneBe;
  logic [DW-1:0]   laneWdata;
  logic [31:0]     loadData;

  assign isMem   = i_valid & (i_memrd | i_memwr);
  assign isStore = i_memwr & ~i_memrd;   // load wins if both are set
  assign inWait  = (state == ST_WAIT);

`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic misalign;

  // Misaligned half/word accesses are trapped and never reach memory.
  always_comb begin
    misalign = 1'b0;
    case (i_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = i_busC[0];
      default: misalign = |i_busC[1:0];
    endcase
  end

  assign memGo = isMem & ~misalign;
`else
  assign memGo = isMem;
`endif

  // Choose between live and captured request fields.
  always_comb begin
    selAddr  = i_busC;
    selData  = i_busB;
    selSize  = i_size;
    selSext  = i_sext;
    selStore = isStore;
    selRd    = i_rd;
    if (inWait) begin
      selAddr  = addrQ;
      selData  = dataQ;
      selSize  = sizeQ;
      selSext  = sextQ;
      selStore = storeQ;
      selRd    = rdQ;
    end
  end

  mem_lane uLane (
    .addrLo   (selAddr[1:0]),
    .size     (selSize),
    .sext     (selSext),
    .storeData(selData),
    .rdata    (dm.dm_rdata),
    .be       (laneBe),
    .wdata    (laneWdata),
    .loadData (loadData)
  );

  // Memory bus and stall; reset kills any request at once, even mid-WAIT.
  always_comb begin
    reqInt      = ~rst & (inWait | memGo);
    dm.dm_req   = reqInt;
    dm.dm_we    = reqInt & selStore;
    dm.dm_addr  = {selAddr[AW-1:2], 2'b00};
    dm.dm_be    = laneBe;
    dm.dm_wdata = laneWdata;
    o_stall     = reqInt & ~dm.dm_ack;
  end

  assign captureEn = ~inWait & memGo & ~dm.dm_ack;

  // Next-state logic: wait only when the access is not acked immediately.
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (memGo && !dm.dm_ack) stateNext = ST_WAIT;
      ST_WAIT: if (dm.dm_ack) stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNext;
  end

  // Capture the request as it enters WAIT so the bus stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrQ  <= '0;
      dataQ  <= '0;
      sizeQ  <= '0;
      sextQ  <= 1'b0;
      storeQ <= 1'b0;
      rdQ    <= '0;
    end else if (captureEn) begin
      addrQ  <= i_busC;
      dataQ  <= i_busB;
      sizeQ  <= i_size;
      sextQ  <= i_sext;
      storeQ <= isStore;
      rdQ    <= i_rd;
    end
  end

  // MEM/WB register: results on completion, bubbles while waiting or trapped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_busW  <= '0;
      o_rd    <= '0;
      o_we    <= 1'b0;
      o_valid <= 1'b0;
`ifdef MEM_STAGE_ADDR_CHECK_EN
      o_adel  <= 1'b0;
      o_ades  <= 1'b0;
`endif
    end else begin
`ifdef MEM_STAGE_ADDR_CHECK_EN
      o_adel <= 1'b0;
      o_ades <= 1'b0;
`endif
      if (reqInt) begin
        if (dm.dm_ack) begin
          o_valid <= 1'b1;
          o_we    <= ~selStore;
          o_rd    <= selStore ? REG_ZERO : selRd;
          o_busW  <= selStore ? '0 : loadData;
        end else begin
          o_valid <= 1'b0;
          o_we    <= 1'b0;
          o_rd    <= REG_ZERO;
          o_busW  <= '0;
        end
      end
`ifdef MEM_STAGE_ADDR_CHECK_EN
      else if (isMem) begin
        o_valid <= 1'b0;
        o_we    <= 1'b0;
        o_rd    <= REG_ZERO;
        o_busW  <= '0;
        o_adel  <= ~isStore;
        o_ades  <= isStore;
      end
`endif
      else begin
        o_valid <= i_valid;
        o_we    <= i_valid;
        o_rd    <= i_valid ? i_rd : REG_ZERO;
        o_busW  <= i_valid ? i_busC : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed, scoreboard-checked bench for mem_stage. Writeback results are
// queued at issue time and compared by an independent monitor.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clk, rst;
  logic [31:0] i_busC, i_busB;
  logic [4:0]  i_rd;
  logic        i_valid, i_memrd, i_memwr, i_sext;
  logic [1:0]  i_size;
  logic [31:0] o_busW;
  logic [4:0]  o_rd;
  logic        o_we, o_valid, o_stall;
`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic        o_adel, o_ades;
`endif

  mem_stage_if #(.AW(32), .DW(32)) dmIf ();

  mem_stage #(.AW(32), .DW(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_busC (i_busC),
    .i_busB (i_busB),
    .i_rd   (i_rd),
    .i_valid(i_valid),
    .i_memrd(i_memrd),
    .i_memwr(i_memwr),
    .i_size (i_size),
    .i_sext (i_sext),
    .dm     (dmIf.master),
    .o_busW (o_busW),
    .o_rd   (o_rd),
    .o_we   (o_we),
    .o_valid(o_valid),
    .o_stall(o_stall)
`ifdef MEM_STAGE_ADDR_CHECK_EN
    ,
    .o_adel (o_adel),
    .o_ades (o_ades)
`endif
  );

  typedef struct {
    logic [31:0] bus;
    logic [4:0]  rd;
    logic        we;
    logic        chkBus;
  } exp_t;

  exp_t sbq[$];
  int   nChecks = 0;
  int   nFail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [31:0] bus, input logic [4:0] rd, input logic we, input logic chkBus);
    exp_t e;
    e.bus = bus; e.rd = rd; e.we = we; e.chkBus = chkBus;
    sbq.push_back(e);
  endtask

  // Monitor: every valid MEM/WB slot must match the oldest queued result.
  always @(negedge clk) begin
    if (!rst && o_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL wb_unexpected: got rd=%0d busW=%h expected no result at %0t", o_rd, o_busW, $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wb_rd", 32'(o_rd), 32'(e.rd));
        chk("wb_we", 32'(o_we), 32'(e.we));
        if (e.chkBus) chk("wb_busW", o_busW, e.bus);
      end
    end
  end

  task automatic setIdle();
    i_valid = 0; i_memrd = 0; i_memwr = 0; i_size = 2'b00; i_sext = 0;
    i_busC = '0; i_busB = '0; i_rd = '0;
    dmIf.dm_ack = 0; dmIf.dm_rdata = '0;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rdF, input logic wrF,
                       input logic [1:0] sz, input logic sx, input logic [31:0] c, input logic [31:0] b);
    i_valid = v; i_rd = rd; i_memrd = rdF; i_memwr = wrF;
    i_size = sz; i_sext = sx; i_busC = c; i_busB = b;
  endtask

  // Zero-wait operation: memory acks in the request cycle when asked.
  task automatic issue(input string tag, input logic v, input logic [4:0] rd, input logic rdF,
                       input logic wrF, input logic [1:0] sz, input logic sx,
                       input logic [31:0] c, input logic [31:0] b, input logic [31:0] rdata,
                       input logic expReq, input logic expWe, input logic [3:0] expBe,
                       input logic [31:0] expWdata, input logic expOutV,
                       input logic [31:0] expBus, input logic [4:0] expRd, input logic expOWe,
                       input logic chkBus);
    @(posedge clk); #1;
    drive(v, rd, rdF, wrF, sz, sx, c, b);
    dmIf.dm_ack = expReq;
    dmIf.dm_rdata = rdata;
    @(negedge clk);
    chk({tag, "_req"}, 32'(dmIf.dm_req), 32'(expReq));
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
    if (expReq) begin
      chk({tag, "_we"}, 32'(dmIf.dm_we), 32'(expWe));
      chk({tag, "_be"}, 32'(dmIf.dm_be), 32'(expBe));
      chk({tag, "_addr"}, dmIf.dm_addr, {c[31:2], 2'b00});
      if (expWe) chk({tag, "_wdata"}, dmIf.dm_wdata, expWdata);
    end
    if (expOutV) pushExp(expBus, expRd, expOWe, chkBus);
    @(posedge clk); #1;
    setIdle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    setIdle();
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_busW", o_busW, 32'd0);
    chk("rst_req", 32'(dmIf.dm_req), 32'd0);
    @(posedge clk); #1;
    rst = 0;

    //       tag     v  rd  rd wr size     sx busC           busB           rdata          req we be       wdata          outV bus            rd   we chkBus
    issue("alu",     1, 5,  0, 0, SZ_WORD, 0, 32'h1234_5678, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         1, 32'h1234_5678, 5,  1, 1);
    issue("alu_r0",  1, 0,  0, 0, SZ_WORD, 0, 32'hCAFE_F00D, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         1, 32'hCAFE_F00D, 0,  1, 1);
    issue("invalid", 0, 3,  1, 0, SZ_WORD, 0, 32'h0000_0040, 32'h0,         32'h0,         0, 0, 4'b0000, 32'h0,         0, 32'h0,         0,  0, 0);
    issue("lb_s",    1, 7,  1, 0, SZ_BYTE, 1, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 1, 0, 4'b1000, 32'h0,         1, 32'hFFFF_FF80, 7,  1, 1);
    issue("lbu",     1, 7,  1, 0, SZ_BYTE, 0, 32'h0000_0103, 32'h0,         32'h80AA_BBCC, 1, 0, 4'b1000, 32'h0,         1, 32'h0000_0080, 7,  1, 1);
    issue("sh",      1, 8,  0, 1, SZ_HALF, 0, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,         1, 1, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0,         0,  0, 0);
    issue("lh_s",    1, 10, 1, 0, SZ_HALF, 1, 32'h0000_0102, 32'h0,         32'h8001_1234, 1, 0, 4'b1100, 32'h0,         1, 32'hFFFF_8001, 10, 1, 1);
    issue("lhu",     1, 11, 1, 0, SZ_HALF, 0, 32'h0000_0100, 32'h0,         32'h8001_9234, 1, 0, 4'b0011, 32'h0,         1, 32'h0000_9234, 11, 1, 1);
    issue("sb",      1, 12, 0, 1, SZ_BYTE, 0, 32'h0000_0101, 32'h0000_00A5, 32'h0,         1, 1, 4'b0010, 32'hA5A5_A5A5, 1, 32'h0,         0,  0, 0);
    issue("rdwr",    1, 13, 1, 1, SZ_WORD, 0, 32'h0000_0204, 32'h5555_5555, 32'h1122_3344, 1, 0, 4'b1111, 32'h0,         1, 32'h1122_3344, 13, 1, 1);
    issue("sw",      1, 14, 0, 1, SZ_WORD, 0, 32'h0000_0208, 32'h0102_0304, 32'h0,         1, 1, 4'b1111, 32'h0102_0304, 1, 32'h0,         0,  0, 0);
`ifndef MEM_STAGE_ADDR_CHECK_EN
    issue("lw_mis",  1, 15, 1, 0, SZ_WORD, 0, 32'h0000_0101, 32'h0,         32'h5566_7788, 1, 0, 4'b1111, 32'h0,         1, 32'h5566_7788, 15, 1, 1);
`endif

    // Word load with ack held off for three cycles.
    @(posedge clk); #1;
    drive(1, 9, 1, 0, SZ_WORD, 0, 32'h0000_0200, 32'h0);
    dmIf.dm_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_stall", 32'(o_stall), 32'd1);
      chk("wait_req", 32'(dmIf.dm_req), 32'd1);
      chk("wait_addr", dmIf.dm_addr, 32'h0000_0200);
      if (i > 0) chk("wait_bubble", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      i_busC = 32'hFFFF_FFF3;   // request must come from captured copy now
    end
    dmIf.dm_ack = 1;
    dmIf.dm_rdata = 32'hA1B2_C3D4;
    @(negedge clk);
    chk("ack_stall", 32'(o_stall), 32'd0);
    chk("ack_addr", dmIf.dm_addr, 32'h0000_0200);
    chk("ack_be", 32'(dmIf.dm_be), 32'hF);
    chk("ack_bubble", 32'(o_valid), 32'd0);
    pushExp(32'hA1B2_C3D4, 9, 1, 1);
    @(posedge clk); #1;
    setIdle();
    @(negedge clk);
    chk("post_stall", 32'(o_stall), 32'd0);
    chk("post_req", 32'(dmIf.dm_req), 32'd0);

    // Reset asserted while waiting: request and stall drop immediately.
    @(posedge clk); #1;
    drive(1, 4, 1, 0, SZ_WORD, 0, 32'h0000_0300, 32'h0);
    @(posedge clk); #1;
    #2 rst = 1;
    #1;
    chk("rstw_req", 32'(dmIf.dm_req), 32'd0);
    chk("rstw_stall", 32'(o_stall), 32'd0);
    chk("rstw_valid", 32'(o_valid), 32'd0);
    setIdle();
    #3 rst = 0;
    @(negedge clk);
    chk("rstw_req2", 32'(dmIf.dm_req), 32'd0);
    chk("rstw_busW", o_busW, 32'd0);
    chk("rstw_we", 32'(o_we), 32'd0);
    issue("alu_post", 1, 6, 0, 0, SZ_WORD, 0, 32'h0BAD_F00D, 32'h0, 32'h0, 0, 0, 4'b0000, 32'h0, 1, 32'h0BAD_F00D, 6, 1, 1);

`ifdef MEM_STAGE_ADDR_CHECK_EN
    // Misaligned word load and half store trap without touching memory.
    @(posedge clk); #1;
    drive(1, 15, 1, 0, SZ_WORD, 0, 32'h0000_0101, 32'h0);
    @(negedge clk);
    chk("adel_req", 32'(dmIf.dm_req), 32'd0);
    chk("adel_stall", 32'(o_stall), 32'd0);
    @(posedge clk); #1;
    setIdle();
    @(negedge clk);
    chk("adel_pulse", 32'(o_adel), 32'd1);
    chk("adel_ades", 32'(o_ades), 32'd0);
    chk("adel_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    drive(1, 2, 0, 1, SZ_HALF, 0, 32'h0000_0103, 32'h1234);
    @(negedge clk);
    chk("adel_end", 32'(o_adel), 32'd0);
    chk("ades_req", 32'(dmIf.dm_req), 32'd0);
    @(posedge clk); #1;
    setIdle();
    @(negedge clk);
    chk("ades_pulse", 32'(o_ades), 32'd1);
    chk("ades_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ades_end", 32'(o_ades), 32'd0);
`endif

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
